// File: rtl/pp_mul_sched_pkg.sv
// ---------------------------------------------------------------------------
// pp_mul_sched_pkg
// Shared types for the pp_pipeline multiplier scheduler.
//   NUM_REQ_MAX : largest supported requester count
//   req_id_t    : requester index carried through the tag pipeline
//   tag_t       : {valid, id} pair that travels alongside each multiplier stage
//   rr_slot()   : index visited at a given offset after the round-robin pointer
// ---------------------------------------------------------------------------
package pp_mul_sched_pkg;

    localparam int NUM_REQ_MAX = 8;
    localparam int REQ_ID_W    = 3;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    // Requester index reached after stepping 'offset' places past 'last',
    // wrapping at 'num'. Offset 1 is the highest-priority candidate.
    function automatic int rr_slot(input req_id_t last, input int offset, input int num);
        return (int'(last) + offset) % num;
    endfunction

endpackage

// File: rtl/pp_pipeline_accel_mul_sched_if.sv
// ---------------------------------------------------------------------------
// pp_pipeline_accel_mul_sched_if
// Requester-side bus of the multiplier scheduler.
//   req_valid / req_ready : per-requester operand handshake (ready is one-hot)
//   req_a / req_b         : packed operands, requester i at [i*W_IN +: W_IN]
//   rsp_valid / rsp_ready : per-requester product handshake (valid at most one-hot)
//   rsp_p                 : shared product bus, qualified by rsp_valid
// Modports: master = requesters, slave = scheduler.
// ---------------------------------------------------------------------------
interface pp_pipeline_accel_mul_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int W_IN    = 11,
    parameter int W_OUT   = 22
);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*W_IN-1:0] req_a;
    logic [NUM_REQ*W_IN-1:0] req_b;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [NUM_REQ-1:0]      rsp_ready;
    logic [W_OUT-1:0]        rsp_p;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p
    );

endinterface

// File: rtl/pp_mul_sched_rr_arb.sv
// ---------------------------------------------------------------------------
// pp_mul_sched_rr_arb
// Round-robin arbiter with a registered "last granted" pointer.
//   clk, reset_n : clock, asynchronous active-low reset
//   req_valid    : request vector
//   en           : grant enable (the multiplier clock enable)
//   gnt          : one-hot grant, combinational
//   gnt_idx      : encoded index of the winner (0 when none)
//   gnt_valid    : a grant is being issued this cycle
// The pointer resets to NUM_REQ-1 so requester 0 has first priority.
// ---------------------------------------------------------------------------
module pp_mul_sched_rr_arb
    import pp_mul_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output req_id_t            gnt_idx,
    output logic               gnt_valid
);

    req_id_t last_gnt_q;
    req_id_t last_gnt_d;

    // Walk the candidates starting one past the pointer; the first valid one
    // wins. Nothing is granted while the multiplier is frozen.
    always_comb begin
        logic found;
        found      = 1'b0;
        gnt        = '0;
        gnt_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (en && !found && req_valid[i] && (i == rr_slot(last_gnt_q, k, NUM_REQ))) begin
                    found      = 1'b1;
                    gnt[i]     = 1'b1;
                    gnt_idx    = req_id_t'(i);
                end
            end
        end
        gnt_valid  = found;
        last_gnt_d = found ? gnt_idx : last_gnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt_q <= req_id_t'(NUM_REQ - 1);
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/pp_pipeline_accel_mul_sched.sv
// ---------------------------------------------------------------------------
// pp_pipeline_accel_mul_sched
// Shares one pipelined unsigned multiplier among NUM_REQ requesters.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : requester bus (slave side): operand and product handshakes
//   mul_ce       : multiplier clock enable; low freezes multiplier and tags
//   mul_din0/1   : operands of the granted requester, 0 when idle
//   mul_dout     : product from the multiplier, MUL_LAT enabled edges later
//   busy         : at least one tag in flight
// A tag {valid, id} shadows every multiplier stage so the product leaving the
// last stage can be routed to its owner. The multiplier's own data is never
// reset; the tag valids alone qualify mul_dout.
// ---------------------------------------------------------------------------
module pp_pipeline_accel_mul_sched
    import pp_mul_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 3,
    parameter int W_IN    = 11,
    parameter int W_OUT   = 22
) (
    input  logic                           clk,
    input  logic                           reset_n,
    pp_pipeline_accel_mul_sched_if.slave   bus,
    output logic                           mul_ce,
    output logic [W_IN-1:0]                mul_din0,
    output logic [W_IN-1:0]                mul_din1,
    input  logic [W_OUT-1:0]               mul_dout,
    output logic                           busy
);

    tag_t [MUL_LAT-1:0] tag_q;
    tag_t [MUL_LAT-1:0] tag_d;
    tag_t               last_tag;

    logic [NUM_REQ-1:0] gnt;
    req_id_t            gnt_idx;
    logic               gnt_valid;
    logic [NUM_REQ-1:0] rsp_valid_int;
    logic               sel_ready;

    assign last_tag = tag_q[MUL_LAT-1];

    // Decode the last-stage owner: raise its response valid and pick up its
    // ready. The id is compared rather than used as an index because it is
    // wider than the requester vector needs.
    always_comb begin
        rsp_valid_int = '0;
        sel_ready     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (last_tag.id == req_id_t'(i)) begin
                rsp_valid_int[i] = last_tag.valid;
                sel_ready        = bus.rsp_ready[i];
            end
        end
    end

    // The whole pipe advances unless a finished product is waiting for an
    // owner that is not ready.
    assign mul_ce        = ~last_tag.valid | sel_ready;
    assign bus.rsp_valid = rsp_valid_int;
    assign bus.rsp_p     = mul_dout;
    assign bus.req_ready = gnt;

    pp_mul_sched_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (bus.req_valid),
        .en        (mul_ce),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Forward the winner's operands; an idle slot feeds zeros.
    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mul_din0 = bus.req_a[i*W_IN +: W_IN];
                mul_din1 = bus.req_b[i*W_IN +: W_IN];
            end
        end
    end

    // Tag shift register, in lockstep with the multiplier stages.
    always_comb begin
        tag_d = tag_q;
        if (mul_ce) begin
            tag_d[0].valid = gnt_valid;
            tag_d[0].id    = gnt_idx;
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_d[s] = tag_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < MUL_LAT; s++) begin
            busy = busy | tag_q[s].valid;
        end
    end

endmodule

// File: tb/tb_pp_pipeline_accel_mul_sched.sv
// ---------------------------------------------------------------------------
// tb_pp_pipeline_accel_mul_sched
// Bench for the multiplier scheduler: a behavioural multiplier, a
// transaction-level reference model with a per-cycle compare process, and
// directed scenarios with hand-computed expectations followed by random traffic.
// ---------------------------------------------------------------------------
module tb_pp_pipeline_accel_mul_sched;

    localparam int NUM_REQ = 4;
    localparam int MUL_LAT = 3;
    localparam int W_IN    = 11;
    localparam int W_OUT   = 22;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             mul_ce;
    logic [W_IN-1:0]  mul_din0;
    logic [W_IN-1:0]  mul_din1;
    logic [W_OUT-1:0] mul_dout;
    logic             busy;

    int compared   = 0;
    int mismatched = 0;

    logic [W_IN-1:0] opA [NUM_REQ] = '{default: '0};
    logic [W_IN-1:0] opB [NUM_REQ] = '{default: '0};

    pp_pipeline_accel_mul_sched_if #(
        .NUM_REQ (NUM_REQ),
        .W_IN    (W_IN),
        .W_OUT   (W_OUT)
    ) bus ();

    pp_pipeline_accel_mul_sched #(
        .NUM_REQ (NUM_REQ),
        .MUL_LAT (MUL_LAT),
        .W_IN    (W_IN),
        .W_OUT   (W_OUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .mul_ce   (mul_ce),
        .mul_din0 (mul_din0),
        .mul_din1 (mul_din1),
        .mul_dout (mul_dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Multiplier: MUL_LAT-deep product pipe that only moves when enabled and
    // is deliberately never reset.
    logic [W_OUT-1:0] mulPipe [MUL_LAT] = '{default: '0};
    always @(posedge clk) begin
        if (mul_ce) begin
            mulPipe[0] <= W_OUT'(mul_din0) * W_OUT'(mul_din1);
            for (int i = 1; i < MUL_LAT; i++) mulPipe[i] <= mulPipe[i-1];
        end
    end
    assign mul_dout = mulPipe[MUL_LAT-1];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ-1:0] ready);
        bus.req_valid = valid;
        bus.rsp_ready = ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*W_IN +: W_IN] = opA[i];
            bus.req_b[i*W_IN +: W_IN] = opB[i];
        end
    endtask

    // Reference model: granted pairs join one in-order list, stamped with the
    // count of enabled edges at grant. A pair is presented once MUL_LAT enabled
    // edges have passed and leaves when its owner accepts it.
    typedef struct {
        int               id;
        logic [W_OUT-1:0] prod;
        longint           t;
    } flight_t;

    flight_t inFlight [$];
    longint  ceCount = 0;
    int      lastGnt = NUM_REQ - 1;

    always @(negedge clk) begin
        logic               outValid;
        int                 outId;
        logic               expCe;
        int                 expWin;
        logic [NUM_REQ-1:0] expRspValid;
        logic [NUM_REQ-1:0] expReady;
        logic [W_IN-1:0]    expA;
        logic [W_IN-1:0]    expB;
        flight_t            entry;
        if (!reset_n) begin
            inFlight.delete();
            lastGnt = NUM_REQ - 1;
            checkOutput("reset rsp_valid", 64'(bus.rsp_valid), 64'(0));
            checkOutput("reset busy", 64'(busy), 64'(0));
            checkOutput("reset mul_ce", 64'(mul_ce), 64'(1));
            if (bus.req_valid == '0) checkOutput("reset req_ready", 64'(bus.req_ready), 64'(0));
        end else begin
            outValid = 1'b0;
            outId    = 0;
            if (inFlight.size() > 0 && inFlight[0].t + MUL_LAT == ceCount) begin
                outValid = 1'b1;
                outId    = inFlight[0].id;
            end
            expRspValid = '0;
            if (outValid) expRspValid[outId] = 1'b1;
            expCe  = !outValid || bus.rsp_ready[outId];
            expWin = -1;
            if (expCe) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int c;
                    c = (lastGnt + k) % NUM_REQ;
                    if (expWin < 0 && bus.req_valid[c]) expWin = c;
                end
            end
            expReady = '0;
            expA     = '0;
            expB     = '0;
            if (expWin >= 0) begin
                expReady[expWin] = 1'b1;
                expA = bus.req_a[expWin*W_IN +: W_IN];
                expB = bus.req_b[expWin*W_IN +: W_IN];
            end
            checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(expRspValid));
            if (outValid) checkOutput("rsp_p", 64'(bus.rsp_p), 64'(inFlight[0].prod));
            checkOutput("mul_ce", 64'(mul_ce), 64'(expCe));
            checkOutput("req_ready", 64'(bus.req_ready), 64'(expReady));
            checkOutput("mul_din0", 64'(mul_din0), 64'(expA));
            checkOutput("mul_din1", 64'(mul_din1), 64'(expB));
            checkOutput("busy", 64'(busy), 64'(inFlight.size() > 0));
            if (outValid && bus.rsp_ready[outId]) void'(inFlight.pop_front());
            if (expWin >= 0) begin
                entry.id   = expWin;
                entry.prod = W_OUT'(expA) * W_OUT'(expB);
                entry.t    = ceCount;
                inFlight.push_back(entry);
                lastGnt = expWin;
            end
            if (expCe) ceCount++;
        end
    end

    task automatic doReset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        applyStimulus('0, '1);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && busy; c++) @(negedge clk);
        checkOutput("drain busy", 64'(busy), 64'(0));
    endtask

    // One pair from an idle pipe: same-cycle grant, product exactly MUL_LAT cycles later.
    task automatic singleShot(input int id, input logic [W_IN-1:0] a, input logic [W_IN-1:0] b,
                              input logic [W_OUT-1:0] expected, input string name);
        @(posedge clk); #1;
        opA[id] = a;
        opB[id] = b;
        applyStimulus(NUM_REQ'(1) << id, '1);
        @(negedge clk);
        checkOutput({name, " grant"}, 64'(bus.req_ready), 64'(1) << id);
        @(posedge clk); #1;
        applyStimulus('0, '1);
        for (int c = 1; c <= MUL_LAT; c++) begin
            @(negedge clk);
            checkOutput({name, " latency"}, 64'(bus.rsp_valid), (c == MUL_LAT) ? (64'(1) << id) : 64'(0));
        end
        checkOutput({name, " product"}, 64'(bus.rsp_p), 64'(expected));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        logic               found;
        int                 idx;
        logic [W_OUT-1:0]   expB2B [3];
        logic [NUM_REQ-1:0] rv;

        $display("[TB] start");
        applyStimulus('0, '1);
        @(negedge clk);
        checkOutput("rst rsp_valid", 64'(bus.rsp_valid), 64'(0));
        checkOutput("rst busy", 64'(busy), 64'(0));
        checkOutput("rst mul_ce", 64'(mul_ce), 64'(1));
        checkOutput("rst req_ready idle", 64'(bus.req_ready), 64'(0));
        applyStimulus(4'b0100, '1);
        #1;
        checkOutput("rst req_ready valid", 64'(bus.req_ready), 64'(4'b0100));
        applyStimulus('0, '1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single requester, largest operands.
        singleShot(0, 11'd2047, 11'd2047, 22'd4190209, "single");

        // All four valid continuously: grants 0,1,2,3,... and products 10,20,30,40,...
        doReset();
        @(posedge clk); #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            opA[i] = W_IN'(i + 1);
            opB[i] = 11'd10;
        end
        applyStimulus('1, '1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput("rr grant", 64'(bus.req_ready), 64'(1) << (c % 4));
            if (c >= MUL_LAT) begin
                checkOutput("rr rsp_valid", 64'(bus.rsp_valid), 64'(1) << ((c - 3) % 4));
                checkOutput("rr rsp_p", 64'(bus.rsp_p), 64'(10 * ((c - 3) % 4 + 1)));
            end
        end
        @(posedge clk); #1;
        applyStimulus('0, '1);
        drain();

        // Backpressure on requester 1 for five cycles.
        doReset();
        @(posedge clk); #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            opA[i] = W_IN'(i + 5);
            opB[i] = 11'd7;
        end
        applyStimulus('1, 4'b1101);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus.rsp_valid == 4'b0010) found = 1'b1;
        end
        checkOutput("bp product reached", 64'(found), 64'(1));
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp mul_ce", 64'(mul_ce), 64'(0));
            checkOutput("bp req_ready", 64'(bus.req_ready), 64'(0));
            checkOutput("bp rsp_p", 64'(bus.rsp_p), 64'(42));
            checkOutput("bp rsp_valid", 64'(bus.rsp_valid), 64'(4'b0010));
            @(negedge clk);
        end
        @(posedge clk); #1;
        applyStimulus('1, '1);
        @(negedge clk);
        checkOutput("bp release mul_ce", 64'(mul_ce), 64'(1));
        checkOutput("bp release rsp_p", 64'(bus.rsp_p), 64'(42));
        @(negedge clk);
        checkOutput("bp next rsp_valid", 64'(bus.rsp_valid), 64'(4'b0100));
        checkOutput("bp next rsp_p", 64'(bus.rsp_p), 64'(49));
        repeat (3) @(posedge clk);
        #1;
        applyStimulus('0, '1);
        drain();

        // Fairness: 0 and 2 alternate, 3 is served promptly, then alternation resumes.
        doReset();
        @(posedge clk); #1;
        applyStimulus(4'b0101, '1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("fair alternate", 64'(bus.req_ready), (c % 2 == 0) ? 64'(4'b0001) : 64'(4'b0100));
        end
        @(posedge clk); #1;
        applyStimulus(4'b1101, '1);
        found = 1'b0;
        for (int c = 0; c < 2 && !found; c++) begin
            @(negedge clk);
            if (bus.req_ready[3]) found = 1'b1;
        end
        checkOutput("fair req3 granted", 64'(found), 64'(1));
        @(posedge clk); #1;
        applyStimulus(4'b0101, '1);
        @(negedge clk);
        checkOutput("fair after3 first", 64'(bus.req_ready), 64'(4'b0001));
        @(negedge clk);
        checkOutput("fair after3 second", 64'(bus.req_ready), 64'(4'b0100));
        @(posedge clk); #1;
        applyStimulus('0, '1);
        drain();

        // Reset with three tags in flight.
        @(posedge clk); #1;
        opA[0] = 11'd100;
        opB[0] = 11'd3;
        applyStimulus(4'b0001, '1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst busy before", 64'(busy), 64'(1));
        @(posedge clk); #1;
        reset_n = 1'b0;
        applyStimulus('0, '1);
        #1;
        checkOutput("midrst rsp_valid", 64'(bus.rsp_valid), 64'(0));
        checkOutput("midrst busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("midrst no stale", 64'(bus.rsp_valid), 64'(0));
        end
        singleShot(1, 11'd25, 11'd40, 22'd1000, "post-reset");

        // Edge operands and back-to-back issue from one requester.
        singleShot(0, 11'd0, 11'd2047, 22'd0, "zero operand");
        singleShot(2, 11'd1, 11'd1, 22'd1, "unit operands");
        expB2B[0] = 22'd12;
        expB2B[1] = 22'd30;
        expB2B[2] = 22'd2047;
        @(posedge clk); #1;
        opA[2] = 11'd3; opB[2] = 11'd4;
        applyStimulus(4'b0100, '1);
        @(posedge clk); #1;
        opA[2] = 11'd5; opB[2] = 11'd6;
        applyStimulus(4'b0100, '1);
        @(posedge clk); #1;
        opA[2] = 11'd2047; opB[2] = 11'd1;
        applyStimulus(4'b0100, '1);
        @(posedge clk); #1;
        applyStimulus('0, '1);
        idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            @(negedge clk);
            if (bus.rsp_valid[2]) begin
                checkOutput("b2b order", 64'(bus.rsp_p), 64'(expB2B[idx]));
                idx++;
            end
        end
        checkOutput("b2b count", 64'(idx), 64'(3));

        // Random traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    opA[i] = ($urandom_range(0, 1) == 1) ? 11'd2047 : 11'd0;
                    opB[i] = 11'd2047;
                end else begin
                    opA[i] = W_IN'($urandom_range(0, 2047));
                    opB[i] = W_IN'($urandom_range(0, 2047));
                end
            end
            rv = NUM_REQ'($urandom);
            applyStimulus(rv, NUM_REQ'($urandom | $urandom));
        end
        @(posedge clk); #1;
        applyStimulus('0, '1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pp_pipeline_accel_mul_sched.md
# pp_pipeline_accel_mul_sched

Round-robin scheduler that shares one pipelined 11x11 unsigned multiplier (fixed latency, clock-enable stall) among `NUM_REQ` requesters in the pp_pipeline accelerator. Each requester issues operand pairs on a valid/ready channel. The scheduler grants at most one pair per cycle, tags it with the requester index, and returns the 22-bit product to the owning requester on a per-requester valid/ready response channel. It freezes the multiplier through `mul_ce` when a finished product cannot be delivered.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `MUL_LAT`, default 3: clock edges from `mul_din*` sampled (with `mul_ce`=1) to the product valid on `mul_dout`.
- `W_IN`, default 11: operand width, unsigned.
- `W_OUT`, default 22: product width, equal to 2*`W_IN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  operand pair valid, one bit per requester.
- `req_ready`  out  `NUM_REQ`  one-hot grant; the pair is consumed this cycle.
- `req_a`  in  `NUM_REQ*W_IN`  operand A per requester, requester i at bits [i*W_IN +: W_IN].
- `req_b`  in  `NUM_REQ*W_IN`  operand B per requester, same packing as `req_a`.
- `rsp_valid`  out  `NUM_REQ`  product valid for requester i; at most one bit set.
- `rsp_ready`  in  `NUM_REQ`  requester accepts its product.
- `rsp_p`  out  `W_OUT`  product, shared by all requesters; qualified by `rsp_valid`.
- `mul_ce`  out  1  clock enable to the multiplier.
- `mul_din0`  out  `W_IN`  operand A to the multiplier.
- `mul_din1`  out  `W_IN`  operand B to the multiplier.
- `mul_dout`  in  `W_OUT`  product from the multiplier.
- `busy`  out  1  at least one tag is in flight.

## Operation
- Tag pipeline: `MUL_LAT` stages, each holding {valid, id}. It advances only when `mul_ce`=1, in lockstep with the multiplier.
- Output stage: the last stage (stage `MUL_LAT`-1) is aligned with `mul_dout`.
  - `rsp_valid[id]` = last-stage valid.
  - `rsp_p` = `mul_dout`.
- Stall: `mul_ce` = ~last.valid | `rsp_ready[last.id]`. While stalled, no grant is issued and every stage holds.
- Arbitration: round-robin with pointer `last_gnt`.
  - Search starts at `last_gnt`+1 mod `NUM_REQ`.
  - The first index with `req_valid` set wins, and only when `mul_ce`=1.
  - `req_ready` = one-hot winner, combinational.
  - On a grant, `last_gnt` takes the winner index; otherwise `last_gnt` holds.
- Issue:
  - `mul_din0`/`mul_din1` = the winner's operands.
  - Stage 0 is loaded with {1, winner}.
  - With no winner, stage 0 is loaded with valid=0 and `mul_din*` are driven to 0.
- Arithmetic: an unsigned product, computed in the multiplier and passed through unmodified. The scheduler performs no arithmetic.

## Timing
- Reset values, asynchronous on `reset_n`=0:
  - All tag valids = 0 and all tag ids = 0.
  - `last_gnt` = `NUM_REQ`-1, so requester 0 has first priority.
  - Outputs: `rsp_valid`=0, `busy`=0, `mul_ce`=1. `req_ready` = 0 unless `req_valid` is set.
- Reset mid-operation: in-flight products are dropped and their `rsp_valid` is never raised. Multiplier data is not reset; the tag valids alone qualify `mul_dout`.
- Latency: a pair granted at edge k produces `rsp_valid` high in the cycle after edge k+`MUL_LAT`-1, i.e. `MUL_LAT` cycles from grant, when unstalled.
- Throughput: 1 product per cycle across all requesters. One requester held alone at valid gets every slot.
- Simultaneous events:
  - Delivery and a new grant in the same cycle are allowed when `rsp_ready` is high.
  - A requester may be granted while its own earlier products are still in flight.
  - Response order per requester equals its issue order.
- Response hold: `rsp_valid` and `rsp_p` stay stable until accepted; `mul_ce`=0 freezes `mul_dout`.
- Combinational path `rsp_ready` -> `mul_ce` -> `req_ready` is permitted. No path exists from `req_valid` to `rsp_*`.

## Structure
- Package `pp_mul_sched_pkg`: `NUM_REQ_MAX`=8, typedef `req_id_t` (3 bits), typedef `tag_t` {valid, `req_id_t` id}.
- One sub-module: `pp_mul_sched_rr_arb`. It holds the round-robin pointer and takes `req_valid` and `en` (`mul_ce`), returning the one-hot grant and the encoded index.
- The tag shift register and stall logic live in the top level.

## Test plan
- Single requester: requester 0 sends A=2047, B=2047. Expect `req_ready[0]` in the same cycle, then `rsp_valid[0]` with `rsp_p`=4190209 exactly 3 cycles later.
- All 4 requesters valid continuously from reset, every A=i+1, B=10. Expect the grant order 0,1,2,3,0,... and responses 10,20,30,40 in that order, one per cycle.
- Backpressure:
  - `rsp_ready[1]` is held low for 5 cycles while requester 1's product is at the output.
  - Expect `mul_ce`=0, all `req_ready`=0, and `rsp_p` constant.
  - After release, the remaining products arrive in order with none lost or duplicated.
- Fairness: requesters 0 and 2 are always valid and requester 3 pulses valid once. Expect requester 3 granted within 2 grants, and requesters 0 and 2 alternating.
- Reset mid-flight: `reset_n` is asserted low with 3 tags in flight. Expect `rsp_valid`=0 and `busy`=0 immediately and no stale responses after release. The next request from requester 1 completes in 3 cycles.
- Edge operands: A=0, B=2047 gives 0; A=1, B=1 gives 1. Back-to-back issue from the same requester returns results in order.
